mod_hk_ctrl: RTL

MOD_HK_CTRL -- requirements
Module: mod_hk_ctrl

---
 rtl/mod_hk_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mod_hk_ctrl.sv
// Loads the 8 H + 64 K constants from a synchronous ROM into a byte-banked RAM, then
// arbitrates round-robin RAM reads between two requesters.
module mod_hk_ctrl #(
  parameter int unsigned N_WORDS = 72,
  parameter int unsigned AW      = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  output logic [3:0]    ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rd_data,
  output logic          done
);

  localparam logic [AW-1:0] LastAddr = AW'(N_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StMemInitDone} state_t;

  state_t        state_q;
  logic [AW-1:0] rom_addr_q;
  logic          wr_q;
  logic [AW-1:0] waddr_q;
  logic          rr_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          done_q;
  logic          rd_en;

  // rom_addr_q doubles as the load counter; wr_q/waddr_q trail it by the ROM latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      rr_q       <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_q      <= (state_q == StLoad);
      waddr_q   <= rom_addr_q;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rr_q <= 1'b1;
      end else if (gnt1) begin
        rr_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (START) begin
            state_q    <= StLoad;
            rom_addr_q <= '0;
            rr_q       <= 1'b0;
          end
        end
        StLoad: begin
          if (rom_addr_q == LastAddr) begin
            rom_addr_q <= '0;
            state_q    <= StFlush;
          end else begin
            rom_addr_q <= rom_addr_q + AW'(1);
          end
        end
        StFlush: begin
          // Stay until the final word has been written.
          if (!wr_q) begin
            state_q <= StMemInitDone;
            done_q  <= 1'b1;
          end
        end
        StMemInitDone: begin
          if (START) begin
            state_q    <= StLoad;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            rr_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A reload request wins over reads in the same cycle.
  always_comb begin
    rd_en     = (state_q == StMemInitDone) && !START;
    gnt0      = rd_en && req0 && (!req1 || !rr_q);
    gnt1      = rd_en && req1 && (!req0 || rr_q);
    ram_re    = gnt0 || gnt1;
    ram_we    = {4{wr_q}};
    ram_wdata = wr_q ? rom_data : 32'h0;
    if (wr_q) begin
      ram_addr = waddr_q;
    end else if (gnt0) begin
      ram_addr = addr0;
    end else if (gnt1) begin
      ram_addr = addr1;
    end else begin
      ram_addr = '0;
    end
  end

  // The RAM output register already provides the one-cycle read latency.
  assign rd_data  = (rvalid0_q || rvalid1_q) ? ram_rdata : 32'h0;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rom_addr = rom_addr_q;
  assign done     = done_q;

  assert property (@(posedge CLK) disable iff (RST) !(ram_re && (ram_we != 4'h0)));
  assert property (@(posedge CLK) disable iff (RST) !(gnt0 && gnt1));

endmodule
